addsub_serial: RTL
==================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter BUS_WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter DIGIT_WIDTH, default 2: bits processed per cycle; SHALL divide BUS_WIDTH exactly, with 1 <= DIGIT_WIDTH <= BUS_WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 A  input  BUS_WIDTH  first operand.
REQ-007 B  input  BUS_WIDTH  second operand.
REQ-008 Cin  input  1  carry in; acts as not-borrow in subtract mode.
REQ-009 mode  input  1  1 = add, 0 = subtract.
REQ-010 sum  output  BUS_WIDTH  registered result.
REQ-011 Cout  output  1  registered carry out; in subtract mode 1 = no borrow.
REQ-012 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-013 done  output  1  one-cycle pulse marking a new valid result.
REQ-014 V, Z, N  output  1 each  overflow, zero and negative flags; present only per REQ-031.

Function
REQ-015 Result: mode=1 SHALL give {Cout,sum} = A + B + Cin; mode=0 SHALL give {Cout,sum} = A + ~B + Cin, all modulo 2^(BUS_WIDTH+1).
REQ-016 Digit count: NDIG = BUS_WIDTH/DIGIT_WIDTH; one digit per cycle, least significant digit first, with a single registered carry passed between digits.
REQ-017 States: IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE: start=1 at an edge SHALL capture A, B (inverted if mode=0) and Cin into internal registers, clear the digit counter and enter RUN.
REQ-019 IDLE: start=0 SHALL stay in IDLE.
REQ-020 RUN: each edge SHALL process one digit and increment the counter; the edge processing digit NDIG-1 SHALL enter DONE.
REQ-021 DONE: sum and Cout SHALL be written at the edge that enters DONE; done=1 for exactly that one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-022 Latency: start sampled at edge E0 -> done high in the cycle after edge E0+NDIG; back-to-back throughput is one result per NDIG+2 cycles.
REQ-023 start while busy=1 (RUN or DONE) SHALL be ignored and not queued.
REQ-024 A, B, Cin and mode SHALL be sampled only at the accepting edge; later changes SHALL not affect the result in progress.
REQ-025 sum and Cout SHALL hold their last value until the next DONE entry; they SHALL never expose partial digits.
REQ-026 NDIG=1: RUN SHALL last exactly one cycle, with the same state sequence.
REQ-027 Carry wrap: the carry out of the top digit SHALL become Cout; no carry SHALL propagate into the next operation.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, sum=0, Cout=0, busy=0, done=0, V=Z=N=0, and clear the internal operand, carry and counter registers.
REQ-029 rst during RUN or DONE SHALL abort the operation: no done pulse and no result update.
REQ-030 rst SHALL take priority over start on the same edge.

Configuration
REQ-031 Macro ADDSUB_SERIAL_FLAGS_EN defined: ports V, Z and N SHALL exist and be registered at DONE entry together with sum.
- Z = (sum==0).
- N = sum[BUS_WIDTH-1].
- V = carry into the MSB XOR Cout, i.e. two's-complement overflow.
REQ-032 Macro ADDSUB_SERIAL_FLAGS_EN undefined: ports V, Z and N and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Defaults. A=0x7F, B=0x01, mode=1, Cin=0 -> sum=0x80, Cout=0, V=1, N=1, Z=0, done high in the cycle after edge E0+4.
REQ-034 Subtract with borrow. A=0x05, B=0x07, mode=0, Cin=1 -> sum=0xFE, Cout=0, N=1, V=0. Subtract without borrow: A=0x10, B=0x10, mode=0, Cin=1 -> sum=0x00, Cout=1, Z=1.
REQ-035 Carry wrap. A=0xFF, B=0x01, mode=1, Cin=0 -> sum=0x00, Cout=1, Z=1, V=0.
REQ-036 Busy rejection. Start A=0x01, B=0x02 (add), then pulse start during RUN with A=0x50 -> single done pulse, sum=0x03. A later start in IDLE is accepted normally.
REQ-037 Reset mid-operation. Assert rst during the 2nd RUN cycle -> next cycle busy=0, sum=0, no done pulse. A new start then completes correctly.
REQ-038 Parameter sweep. BUS_WIDTH=16 with DIGIT_WIDTH=16, then DIGIT_WIDTH=1; A=0x8000, B=0x8000, mode=1 -> sum=0x0000, Cout=1, V=1. done appears after 1 and 16 RUN cycles respectively.

Source files
------------

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial adder/subtractor with registered result.
// Optional V/Z/N flag ports are built when ADDSUB_SERIAL_FLAGS_EN is defined.
module addsub_serial #(
  parameter int BUS_WIDTH   = 8,
  parameter int DIGIT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] A,
  input  logic [BUS_WIDTH-1:0] B,
  input  logic                 Cin,
  input  logic                 mode,
  output logic [BUS_WIDTH-1:0] sum,
  output logic                 Cout,
  output logic                 busy,
  output logic                 done
`ifdef ADDSUB_SERIAL_FLAGS_EN
  ,
  output logic                 V,
  output logic                 Z,
  output logic                 N
`endif
);

  localparam int NDIG = BUS_WIDTH / DIGIT_WIDTH;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BUS_WIDTH-1:0] a_reg;
  logic [BUS_WIDTH-1:0] b_reg;
  logic [BUS_WIDTH-1:0] acc_reg;
  logic                 carry_reg;
  logic [CW-1:0]        cnt;

  logic [DIGIT_WIDTH-1:0] a_dig;
  logic [DIGIT_WIDTH-1:0] b_dig;
  logic [DIGIT_WIDTH:0]   dig_sum;
  logic [BUS_WIDTH-1:0]   acc_nxt;
  logic                   last_dig;

  // One digit slice per cycle; partial results collect in acc_reg, never in sum.
  always_comb begin
    a_dig    = a_reg[int'(cnt) * DIGIT_WIDTH +: DIGIT_WIDTH];
    b_dig    = b_reg[int'(cnt) * DIGIT_WIDTH +: DIGIT_WIDTH];
    dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_WIDTH{1'b0}}, carry_reg};
    acc_nxt  = acc_reg;
    acc_nxt[int'(cnt) * DIGIT_WIDTH +: DIGIT_WIDTH] = dig_sum[DIGIT_WIDTH-1:0];
    last_dig = (cnt == CW'(NDIG - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      Cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= mode ? B : ~B;
            carry_reg <= Cin;
            acc_reg   <= '0;
            cnt       <= '0;
          end
        end
        RUN: begin
          acc_reg   <= acc_nxt;
          carry_reg <= dig_sum[DIGIT_WIDTH];
          cnt       <= cnt + CW'(1);
          if (last_dig) begin
            sum  <= acc_nxt;
            Cout <= dig_sum[DIGIT_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDSUB_SERIAL_FLAGS_EN
  // Overflow when both effective operands share a sign the result does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      V <= 1'b0;
      Z <= 1'b0;
      N <= 1'b0;
    end else if (state == RUN && last_dig) begin
      V <= (a_reg[BUS_WIDTH-1] == b_reg[BUS_WIDTH-1]) &&
           (acc_nxt[BUS_WIDTH-1] != a_reg[BUS_WIDTH-1]);
      Z <= (acc_nxt == '0);
      N <= acc_nxt[BUS_WIDTH-1];
    end
  end
`endif

endmodule
